// File: rtl/seq_det_pkg.sv
// Shared definitions for the word-level sequence detector controller:
// FSM state encoding and default word / total widths.
package seq_det_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int TOT_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/seq_det_ctrl.sv
// Feeds parallel words MSB-first into a serial Mealy detector, holding the detector
// in reset between words, and reports per-bit hits, per-word count and a saturating total.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = $clog2(WIDTH + 1),
   parameter int TOT_W = TOT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             det_rst,
   output logic             det_x,
   input  logic             det_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_hits,
   output logic [CNT_W-1:0] out_count,
   output logic [TOT_W-1:0] hit_total,
   output logic             busy
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int SUM_W = TOT_W + 1;
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] data_q;
   logic [IDX_W-1:0] idx;
   logic [SUM_W-1:0] total_sum;
   logic             accept;
   logic             release_w;
   logic             last_bit;

   // Handshake outputs depend on state only, never on the partner's valid/ready.
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);

   assign accept    = in_ready && in_valid;
   assign release_w = out_valid && out_ready;
   assign last_bit  = (idx == '0);
   assign total_sum = SUM_W'(hit_total) + SUM_W'(out_count);

   always_comb begin
      // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned (no latch).
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept)    state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_bit)  state_nxt = ST_DONE;
         ST_DONE:  if (release_w) state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         data_q    <= '0;
         idx       <= '0;
         det_rst   <= 1'b1;
         det_x     <= 1'b0;
         out_hits  <= '0;
         out_count <= '0;
         hit_total <= '0;
      end else begin
         // NOTE: non-blocking assignments: every register here updates from pre-edge values.
         state   <= state_nxt;
         // Registered so the detector is out of reset for exactly the SHIFT cycles.
         det_rst <= (state_nxt != ST_SHIFT);
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  data_q    <= in_data;
                  idx       <= IDX_MSB;
                  out_hits  <= '0;
                  out_count <= '0;
                  det_x     <= in_data[WIDTH-1];
               end
            end
            ST_SHIFT: begin
               out_hits[idx] <= det_z;
               out_count     <= out_count + CNT_W'(det_z);
               if (last_bit) begin
                  det_x <= 1'b0;
               end else begin
                  idx   <= idx - 1'b1;
                  det_x <= data_q[idx - 1'b1];
               end
            end
            ST_DONE: begin
               if (release_w)
                  hit_total <= total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule
